// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier round-robin arbiter.
// Holds the FSM state encoding, default parameter values and a helper
// for sizing requester index fields.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 8;
  localparam int DEF_TIMEOUT = 15;
  localparam int IDX_W       = $clog2(DEF_N_REQ);

  // Index width for an arbitrary requester count; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   in  N_REQ   request vector
//   last  in  PICK_W  index served most recently
//   valid out 1       at least one request present
//   idx   out PICK_W  first set request searching upward from last+1 (mod N_REQ)
module rr_pick
  import mul_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int PICK_W = idx_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0]  req,
  input  logic [PICK_W-1:0] last,
  output logic              valid,
  output logic [PICK_W-1:0] idx
);

  int               k;
  logic [N_REQ-1:0] sh;

  // Scan from the farthest candidate to the nearest so the nearest hit
  // after last is the one that sticks.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    k     = 0;
    sh    = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k  = (int'(last) + i) % N_REQ;
      sh = req >> k;
      if (sh[0]) begin
        valid = 1'b1;
        idx   = PICK_W'(k);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end for a shared sequential 8-cycle multiplier.
// Grants one requester, latches its operands, launches the multiplier,
// waits for completion (with a watchdog) and returns the product with a
// one-cycle one-hot done pulse.
// Ports:
//   clk_i        in  1        clock
//   rst_n_i      in  1        asynchronous active-low reset
//   req_i        in  N_REQ    request levels
//   a_bi, b_bi   in  N_REQ*W  packed operands, requester k at [k*W +: W]
//   done_o       out N_REQ    one-hot completion pulse
//   err_o        out 1        watchdog abort flag, coincident with done_o
//   y_bo         out 2*W      product, held until the next completion
//   busy_o       out 1        not idle
//   mul_start_o  out 1        multiplier start pulse
//   mul_a_bo/_b  out W        latched operands to the multiplier
//   mul_busy_i   in  1        multiplier busy
//   mul_y_bi     in  2*W      multiplier result
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*W-1:0] a_bi,
  input  logic [N_REQ*W-1:0] b_bi,
  output logic [N_REQ-1:0]   done_o,
  output logic               err_o,
  output logic [2*W-1:0]     y_bo,
  output logic               busy_o,
  output logic               mul_start_o,
  output logic [W-1:0]       mul_a_bo,
  output logic [W-1:0]       mul_b_bo,
  input  logic               mul_busy_i,
  input  logic [2*W-1:0]     mul_y_bi
);

  localparam int GIDX_W = idx_width(N_REQ);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [GIDX_W-1:0]  grant_q, last_q, pick_idx;
  logic               pick_vld;
  logic [CNT_W-1:0]   wd_cnt_q;
  logic [N_REQ-1:0]   grant_oh;
  logic               run_done, run_abort;

  rr_pick #(
    .N_REQ  (N_REQ),
    .PICK_W (GIDX_W)
  ) u_pick (
    .req   (req_i),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign grant_oh = N_REQ'(1) << grant_q;
  // The multiplier raises busy on the LAUNCH edge, so its busy level is
  // only meaningful once the counter has left zero.
  assign run_done  = (wd_cnt_q != '0) && !mul_busy_i;
  assign run_abort = (wd_cnt_q == CNT_W'(TIMEOUT));
  assign busy_o    = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pick_vld) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_RUN;
      ST_RUN:    if (run_done || run_abort) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // done_o/err_o are set on the edge that enters DONE, so they are high
  // exactly during the DONE cycle; mul_start_o likewise for LAUNCH.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= GIDX_W'(N_REQ - 1);
      wd_cnt_q    <= '0;
      y_bo        <= '0;
      mul_a_bo    <= '0;
      mul_b_bo    <= '0;
      done_o      <= '0;
      err_o       <= 1'b0;
      mul_start_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      mul_start_o <= (state_d == ST_LAUNCH);
      done_o      <= '0;
      err_o       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            grant_q  <= pick_idx;
            mul_a_bo <= a_bi[pick_idx*W +: W];
            mul_b_bo <= b_bi[pick_idx*W +: W];
          end
        end
        ST_LAUNCH: wd_cnt_q <= '0;
        ST_RUN: begin
          if (!run_abort) wd_cnt_q <= wd_cnt_q + 1'b1;
          if (run_done) begin
            y_bo   <= mul_y_bi;
            done_o <= grant_oh;
          end else if (run_abort) begin
            y_bo   <= '0;
            err_o  <= 1'b1;
            done_o <= grant_oh;
          end
        end
        ST_DONE: last_q <= grant_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
module tb_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a, b;
  logic [3:0]  done_o;
  logic        err_o;
  logic [15:0] y_bo;
  logic        busy_o;
  logic        mul_start;
  logic [7:0]  mul_a, mul_b;
  logic        mul_busy;
  logic [15:0] mul_y;

  // multiplier model
  logic [3:0]  m_cnt;
  logic        m_busy;
  logic [7:0]  m_a, m_b;
  logic        stuck;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.N_REQ(4), .W(8), .TIMEOUT(15)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .a_bi        (a),
    .b_bi        (b),
    .done_o      (done_o),
    .err_o       (err_o),
    .y_bo        (y_bo),
    .busy_o      (busy_o),
    .mul_start_o (mul_start),
    .mul_a_bo    (mul_a),
    .mul_b_bo    (mul_b),
    .mul_busy_i  (mul_busy),
    .mul_y_bi    (mul_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 4'd0;
      m_busy <= 1'b0;
      mul_y  <= 16'd0;
      m_a    <= 8'd0;
      m_b    <= 8'd0;
    end else if (mul_start) begin
      m_cnt  <= 4'd8;
      m_busy <= 1'b1;
      m_a    <= mul_a;
      m_b    <= mul_b;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 4'd1;
      if (m_cnt == 4'd1) begin
        m_busy <= 1'b0;
        mul_y  <= {8'h00, m_a} * {8'h00, m_b};
      end
    end
  end
  assign mul_busy = m_busy | stuck;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic wait_done(input int maxc, output int n, output logic ok);
    n  = 0;
    ok = 1'b0;
    while (n < maxc) begin
      @(posedge clk);
      #1;
      n++;
      if (done_o != 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_idx;
    logic [15:0] exp_y;
  } vec_t;

  localparam logic [31:0] OPS_A = 32'h1000FF03;  // (3,255,0,16)
  localparam logic [31:0] OPS_B = 32'h104DFF05;  // (5,255,77,16)

  vec_t vecs[8];
  int   rr_idx[5];
  int   rr_y[5];

  initial begin
    int   n;
    logic ok;
    logic [3:0] exp_done;
    int   done_seen;

    vecs[0] = '{4'b0001, 32'h0000000C, 32'h0000000B, 0, 16'd132};
    vecs[1] = '{4'b1111, OPS_A, OPS_B, 1, 16'd65025};
    vecs[2] = '{4'b1001, OPS_A, OPS_B, 3, 16'd256};
    vecs[3] = '{4'b0101, OPS_A, OPS_B, 0, 16'd15};
    vecs[4] = '{4'b0100, OPS_A, OPS_B, 2, 16'd0};
    vecs[5] = '{4'b0101, OPS_A, OPS_B, 0, 16'd15};
    vecs[6] = '{4'b0101, OPS_A, OPS_B, 2, 16'd0};
    vecs[7] = '{4'b0011, OPS_A, OPS_B, 0, 16'd15};
    rr_idx = '{0, 1, 2, 3, 0};
    rr_y   = '{15, 65025, 0, 256, 15};

    rst_n = 1'b0; req = 4'd0; a = 32'd0; b = 32'd0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 0, 32'(done_o), 0);
    check("rst_err", 0, 32'(err_o), 0);
    check("rst_start", 0, 32'(mul_start), 0);
    check("rst_busy", 0, 32'(busy_o), 0);
    check("rst_y", 0, 32'(y_bo), 0);
    check("rst_mula", 0, 32'(mul_a), 0);
    check("rst_mulb", 0, 32'(mul_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // continuous round robin from reset
    @(negedge clk);
    a = OPS_A; b = OPS_B; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(40, n, ok);
      check("rr_timeout", k, 32'(ok), 1);
      exp_done = 4'b0001 << rr_idx[k];
      check("rr_done", k, 32'(done_o), 32'(exp_done));
      check("rr_y", k, 32'(y_bo), 32'(rr_y[k]));
      check("rr_err", k, 32'(err_o), 0);
      check("rr_gap", k, 32'(n), (k == 0) ? 11 : 12);
      if (k == 0) check("rr_busy", k, 32'(busy_o), 1);
    end
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);

    // directed vector table
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; req = vecs[i].req;
      wait_done(40, n, ok);
      check("vec_timeout", i, 32'(ok), 1);
      exp_done = 4'b0001 << vecs[i].exp_idx;
      check("vec_done", i, 32'(done_o), 32'(exp_done));
      check("vec_y", i, 32'(y_bo), 32'(vecs[i].exp_y));
      check("vec_err", i, 32'(err_o), 0);
      check("vec_lat", i, 32'(n), 11);
      req = 4'd0;
      @(negedge clk);
      @(negedge clk);
    end

    // operand change after grant
    @(negedge clk);
    a = 32'h00000700; b = 32'h00000900; req = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    a = 32'h00006400;
    wait_done(40, n, ok);
    check("hold_timeout", 0, 32'(ok), 1);
    check("hold_done", 0, 32'(done_o), 32'h2);
    check("hold_y", 0, 32'(y_bo), 63);
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);

    // watchdog abort with stuck multiplier
    stuck = 1'b1;
    @(negedge clk);
    a = 32'h00000005; b = 32'h00000005; req = 4'b0001;
    n = 0; ok = 1'b0;
    while (n < 10 && !ok) begin
      @(posedge clk);
      #1;
      n++;
      if (mul_start) ok = 1'b1;
    end
    check("wd_launch", 0, 32'(ok), 1);
    check("wd_launch_cyc", 0, 32'(n), 1);
    wait_done(40, n, ok);
    check("wd_timeout", 0, 32'(ok), 1);
    check("wd_cycles", 0, 32'(n), 17);
    check("wd_done", 0, 32'(done_o), 32'h1);
    check("wd_err", 0, 32'(err_o), 1);
    check("wd_y", 0, 32'(y_bo), 0);
    req = 4'd0;
    stuck = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    a = 32'h00090000; b = 32'h00090000; req = 4'b0100;
    wait_done(40, n, ok);
    check("wd_next_timeout", 0, 32'(ok), 1);
    check("wd_next_done", 0, 32'(done_o), 32'h4);
    check("wd_next_err", 0, 32'(err_o), 0);
    check("wd_next_y", 0, 32'(y_bo), 81);
    check("wd_next_lat", 0, 32'(n), 11);
    req = 4'd0;
    @(negedge clk);
    @(negedge clk);

    // reset in the middle of RUN
    @(negedge clk);
    a = 32'h0000000C; b = 32'h0000000B; req = 4'b0001;
    repeat (5) @(posedge clk);
    #2;
    check("mid_busy_before", 0, 32'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", 0, 32'(busy_o), 0);
    check("mid_start", 0, 32'(mul_start), 0);
    check("mid_done", 0, 32'(done_o), 0);
    check("mid_err", 0, 32'(err_o), 0);
    check("mid_y", 0, 32'(y_bo), 0);
    check("mid_mula", 0, 32'(mul_a), 0);
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done_o != 4'd0) done_seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, n, ok);
    check("mid_no_done", 0, 32'(done_seen), 0);
    check("mid_re_timeout", 0, 32'(ok), 1);
    check("mid_re_lat", 0, 32'(n), 11);
    check("mid_re_done", 0, 32'(done_o), 32'h1);
    check("mid_re_y", 0, 32'(y_bo), 132);
    req = 4'd0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin scheduler that shares one sequential 8-bit shift-and-add multiplier between `N_REQ` requesters. The multiplier accepts a start pulse, holds `busy` for 8 cycles, and updates its 16-bit result on the same edge that drops `busy`. This block sits directly in front of that multiplier. It does the following:

- latches one requester's operands and launches the multiplier;
- waits for completion;
- returns the product to the granted requester with a one-cycle done pulse;
- supervises the multiplier with a watchdog.

## Interface
- `N_REQ`, default 4, number of requesters (2..8).
- `W`, default 8, operand width; product width is `2*W`.
- `TIMEOUT`, default 15, maximum RUN cycles before abort (must exceed 8).

- `clk_i`  in  1  clock, all logic on rising edge.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `req_i`  in  N_REQ  per-requester request level; held until matching `done_o` bit.
- `a_bi`  in  N_REQ*W  packed operands A, requester k at `[k*W +: W]`; stable while `req_i[k]`=1.
- `b_bi`  in  N_REQ*W  packed operands B, same packing.
- `done_o`  out  N_REQ  one-hot one-cycle completion pulse.
- `err_o`  out  1  one-cycle pulse coincident with `done_o` when the watchdog aborted.
- `y_bo`  out  2*W  result, valid in the `done_o` cycle, held until next DONE.
- `busy_o`  out  1  high in any state other than IDLE.
- `mul_start_o`  out  1  start pulse to the multiplier.
- `mul_a_bo`, `mul_b_bo`  out  W each  latched operands to the multiplier.
- `mul_busy_i`  in  1  multiplier busy.
- `mul_y_bi`  in  2*W  multiplier result.

## Operation
- **States:** IDLE, LAUNCH, RUN, DONE.
- **IDLE, no request:** if `req_i`==0, stay in IDLE.
- **IDLE, arbitration:** otherwise grant the first set bit searching upward from `last+1` modulo `N_REQ`.
  - On the same edge: register the grant index, latch `a`/`b` into `mul_a_bo`/`mul_b_bo`, and go to LAUNCH.
  - After reset, `last`=`N_REQ-1`, so requester 0 has top priority.
- **LAUNCH:** `mul_start_o`=1 for exactly this cycle; go to RUN. The watchdog counter is cleared.
- **RUN, normal completion:** `mul_busy_i` is ignored in the first RUN cycle, because the multiplier raises it on the LAUNCH edge. From the second RUN cycle on, `mul_busy_i`==0 means complete: capture `mul_y_bi` into `y_bo` and go to DONE.
- **RUN, watchdog abort:** if the counter reaches `TIMEOUT`, set `y_bo`=0, flag an error, and go to DONE.
- **DONE:**
  - `done_o[grant]`=1; `err_o`=flag; `last`<=grant.
  - Go to IDLE; the next arbitration happens in IDLE.
- **Requester drops `req_i` mid-operation:** the operation still completes and `done_o` still pulses; the requester ignores it.
- **Requester keeps `req_i` high after done:** it is re-eligible but ranks last.
- **Operand changes after grant:** have no effect, because operands are latched at grant.
- **Reset values:**
  - State IDLE.
  - `done_o`, `err_o`, `mul_start_o`, `busy_o` = 0.
  - `y_bo`, `mul_a_bo`, `mul_b_bo` = 0.
- **Reset mid-operation:** the block returns to IDLE immediately. The integration drives the multiplier reset with `~rst_n_i`, so both blocks restart together. No `done_o` is issued for the aborted operation.

## Timing
- With `req_i` sampled in cycle 0:
  - cycle 1: LAUNCH;
  - cycles 2–9: RUN with multiplier busy;
  - cycle 10: busy low, result captured;
  - cycle 11: `done_o`.
- Latency is 11 cycles from request to done. Throughput is one product per 12 cycles under continuous requests.
- Watchdog abort: `done_o`/`err_o` arrive `TIMEOUT`+2 cycles after LAUNCH.
- `done_o` is registered and `mul_start_o` is a registered decode of LAUNCH, so neither output has a combinational path from inputs.

## Structure
- Package `mul_arb_pkg`:
  - state encoding (enum / localparams `ST_IDLE`..`ST_DONE`);
  - `IDX_W` = clog2(`N_REQ`);
  - default `W` and `TIMEOUT`.
- Sub-module `rr_pick`: purely combinational; takes `req` and `last` and returns `valid` plus `idx`. Instantiated once.
- The FSM, operand/result registers and watchdog counter live in `mul_arbiter`.

## Test plan
- **Single request:** `req_i`=0001, a0=12, b0=11 → `mul_start_o` in cycle 1; `done_o`=0001 with `y_bo`=132 in cycle 11; `err_o`=0.
- **Round robin:** all four requesting continuously with operands (3,5),(255,255),(0,77),(16,16) → done order 0,1,2,3,0. Products are 15, 65025, 0, 256. Done pulses are 12 cycles apart.
- **Fairness after wrap:** only req 2 and req 0 active, last served = 2 → req 0 is granted next, then req 2.
- **Watchdog:** the multiplier model holds busy high permanently → `done_o`=grant bit, `err_o`=1, `y_bo`=0, `TIMEOUT`+2 cycles after LAUNCH; the next request is served normally.
- **Reset mid-RUN:** assert `rst_n_i` low in cycle 5 → all outputs reach reset values asynchronously and no `done_o` pulses. After release, a held `req_i` restarts with an 11-cycle latency.
- **Operand hold:** change `a_bi` in cycle 3 of an operation → `y_bo` reflects the operands latched at grant.
